// File: rtl/rmii_rx_framer_pkg.sv
// Shared types and wire constants for the Ethernet PHY receive front end.
package eth_rx_pkg;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} rx_state_t;

  localparam int ETH_MAX_LEN = 1522;

  // Preamble slice: the low W bits of 0x55.
  function automatic logic [7:0] pre_pat(input int w);
    logic [7:0] mask;
    mask = 8'((1 << w) - 1);
    return 8'h55 & mask;
  endfunction

  // SFD slice: the top W bits of 0xD5, i.e. the last slice on the wire.
  function automatic logic [7:0] sfd_pat(input int w);
    return 8'hD5 >> (8 - w);
  endfunction

endpackage

// File: rtl/rmii_rx_framer_if.sv
// PHY-side inputs and byte-stream outputs of the receive framer.
interface rmii_rx_framer_if #(
  parameter int W = 2
);
  logic         speed10;
  logic         crs_dv;
  logic [W-1:0] rx_d;
  logic         rx_er;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_sof;
  logic         rx_eof;
  logic         rx_err;
  logic [15:0]  rx_len;

  modport master (
    output speed10, crs_dv, rx_d, rx_er,
    input  rx_data, rx_valid, rx_sof, rx_eof, rx_err, rx_len
  );

  modport slave (
    input  speed10, crs_dv, rx_d, rx_er,
    output rx_data, rx_valid, rx_sof, rx_eof, rx_err, rx_len
  );
endinterface

// File: rtl/rmii_rx_framer_strobe.sv
// Slice sample strobe: every clock at 100 Mb/s, once per DIV10 clocks at 10 Mb/s.
module rmii_rx_strobe #(
  parameter int DIV10     = 10,
  parameter int SAMPLE_PH = 5
) (
  input  logic clk,
  input  logic resetn,
  input  logic speed10,
  input  logic hold,
  output logic sample_en
);

  localparam int CW = (DIV10 > 1) ? $clog2(DIV10) : 1;

  logic [CW-1:0] div_cnt;

  // Holding at 0 while idle re-aligns the sample phase to each carrier rise.
  always_ff @(posedge clk) begin
    if (!resetn)
      div_cnt <= '0;
    else if (!speed10 || hold)
      div_cnt <= '0;
    else if (div_cnt == CW'(DIV10 - 1))
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign sample_en = !speed10 || (div_cnt == CW'(SAMPLE_PH));

endmodule

// File: rtl/rmii_rx_framer.sv
// PHY receive framer: preamble/SFD strip, LSB-first byte assembly, CRS_DV toggle handling.
module rmii_rx_framer
  import eth_rx_pkg::*;
#(
  parameter int W          = 2,
  parameter int MIN_PRE    = 4,
  parameter int DIV10      = 10,
  parameter int SAMPLE_PH  = 5,
  parameter int MAX_LEN    = ETH_MAX_LEN,
  parameter int CRS_TOGGLE = 1
) (
  input logic             clk,
  input logic             resetn,
  rmii_rx_framer_if.slave rx
);

  localparam int SLICES = 8 / W;
  localparam int SC_W   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int PC_W   = $clog2(MIN_PRE + 1) + 1;
  localparam int PC_MAX = (1 << PC_W) - 1;

  localparam logic [W-1:0] PRE = W'(pre_pat(W));
  localparam logic [W-1:0] SFD = W'(sfd_pat(W));

  rx_state_t       state;
  logic [PC_W-1:0] pre_cnt;
  logic [SC_W-1:0] slice_cnt;
  logic [15:0]     len;
  logic            err_flag;
  logic            dv_low;
  logic [7:0]      byte_buf;
  logic [7:0]      byte_nx;
  logic            strobe;
  logic            hold;
  logic            accept;
  logic            clean_end;

  assign hold = (state == IDLE) && !rx.crs_dv;

  rmii_rx_strobe #(
    .DIV10    (DIV10),
    .SAMPLE_PH(SAMPLE_PH)
  ) u_strobe (
    .clk      (clk),
    .resetn   (resetn),
    .speed10  (rx.speed10),
    .hold     (hold),
    .sample_en(strobe)
  );

  always_comb begin
    byte_nx = byte_buf;
    for (int k = 0; k < SLICES; k++)
      if (slice_cnt == SC_W'(k))
        byte_nx[W*k +: W] = rx.rx_d;
  end

  // In toggle mode the first low sample may still carry data; only a second low ends the frame.
  assign accept    = rx.crs_dv || ((CRS_TOGGLE != 0) && !dv_low);
  assign clean_end = (CRS_TOGGLE != 0) ? (slice_cnt == SC_W'(1)) : (slice_cnt == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      pre_cnt     <= '0;
      slice_cnt   <= '0;
      len         <= '0;
      err_flag    <= 1'b0;
      dv_low      <= 1'b0;
      rx.rx_data  <= '0;
      rx.rx_valid <= 1'b0;
      rx.rx_sof   <= 1'b0;
      rx.rx_eof   <= 1'b0;
      rx.rx_err   <= 1'b0;
      rx.rx_len   <= '0;
    end else begin
      rx.rx_valid <= 1'b0;
      rx.rx_sof   <= 1'b0;
      rx.rx_eof   <= 1'b0;
      if (strobe) begin
        case (state)
          IDLE: begin
            if (rx.crs_dv && rx.rx_d == PRE) begin
              state   <= PREAMBLE;
              pre_cnt <= PC_W'(1);
            end
          end
          PREAMBLE: begin
            if (!rx.crs_dv) begin
              state <= IDLE;
            end else if (rx.rx_d == PRE) begin
              if (pre_cnt != PC_W'(PC_MAX))
                pre_cnt <= pre_cnt + 1'b1;
            end else if (rx.rx_d == SFD && int'(pre_cnt) >= MIN_PRE) begin
              state     <= DATA;
              slice_cnt <= '0;
              len       <= '0;
              err_flag  <= 1'b0;
              dv_low    <= 1'b0;
            end else begin
              state <= DROP;
            end
          end
          DROP: begin
            if (!rx.crs_dv)
              state <= IDLE;
          end
          DATA: begin
            if (accept) begin
              byte_buf <= byte_nx;
              dv_low   <= !rx.crs_dv;
              if (rx.rx_er)
                err_flag <= 1'b1;
              if (slice_cnt == SC_W'(SLICES - 1)) begin
                slice_cnt   <= '0;
                rx.rx_valid <= 1'b1;
                rx.rx_data  <= byte_nx;
                rx.rx_sof   <= (len == '0);
                if (len != 16'hFFFF)
                  len <= len + 16'd1;
              end else begin
                slice_cnt <= slice_cnt + 1'b1;
              end
            end else begin
              state     <= IDLE;
              rx.rx_eof <= 1'b1;
              rx.rx_len <= len;
              rx.rx_err <= err_flag || !clean_end || (len == '0) || (int'(len) > MAX_LEN);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Scoreboard bench for rmii_rx_framer (RMII, CRS_DV toggle mode, reduced MAX_LEN).
module tb_rmii_rx_framer;

  localparam int W         = 2;
  localparam int MIN_PRE   = 4;
  localparam int DIV10     = 10;
  localparam int SAMPLE_PH = 5;
  localparam int MAX_LEN   = 24;

  typedef struct {
    bit         is_eof;
    logic [7:0] data;
    bit         sof;
    bit         err;
    int         len;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rmii_rx_framer_if #(.W(W)) bus ();

  rmii_rx_framer #(
    .W         (W),
    .MIN_PRE   (MIN_PRE),
    .DIV10     (DIV10),
    .SAMPLE_PH (SAMPLE_PH),
    .MAX_LEN   (MAX_LEN),
    .CRS_TOGGLE(1)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .rx    (bus)
  );

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         last_valid = 0;
  int         hold_n = 1;
  bit         chk_spacing = 0;
  exp_t       exp_q[$];
  logic [7:0] pl[$];
  logic [1:0] sd[$];
  bit         sdv[$];
  bit         ser[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic extra(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got %0h required no output", name, act);
  endtask

  task automatic chk_outs_zero(input string tag);
    check({tag, "_rx_valid"}, 32'(bus.rx_valid), 0);
    check({tag, "_rx_sof"},   32'(bus.rx_sof),   0);
    check({tag, "_rx_eof"},   32'(bus.rx_eof),   0);
    check({tag, "_rx_err"},   32'(bus.rx_err),   0);
    check({tag, "_rx_data"},  32'(bus.rx_data),  0);
    check({tag, "_rx_len"},   32'(bus.rx_len),   0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  // Monitor: pops the scoreboard whenever the DUT presents a byte or an end of frame.
  always @(negedge clk) begin
    exp_t e;
    if (bus.rx_valid === 1'b1 && bus.rx_eof === 1'b1)
      check("valid_eof_overlap", 1, 0);
    if (bus.rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        extra("unexpected_byte", 32'(bus.rx_data));
      end else begin
        e = exp_q.pop_front();
        check("kind_byte", 32'(e.is_eof), 0);
        check("rx_data", 32'(bus.rx_data), 32'(e.data));
        check("rx_sof", 32'(bus.rx_sof), 32'(e.sof));
        if (chk_spacing && !e.sof)
          check("valid_spacing", 32'(cyc - last_valid), 40);
        last_valid = cyc;
      end
    end
    if (bus.rx_eof === 1'b1) begin
      if (exp_q.size() == 0) begin
        extra("unexpected_eof", 32'(bus.rx_len));
      end else begin
        e = exp_q.pop_front();
        check("kind_eof", 32'(e.is_eof), 1);
        check("rx_len", 32'(bus.rx_len), 32'(e.len));
        check("rx_err", 32'(bus.rx_err), 32'(e.err));
      end
    end
  end

  task automatic add(input bit dv, input logic [1:0] d, input bit er);
    sdv.push_back(dv);
    sd.push_back(d);
    ser.push_back(er);
  endtask

  task automatic play();
    for (int i = 0; i < sd.size(); i++) begin
      bus.crs_dv = sdv[i];
      bus.rx_d   = sd[i];
      bus.rx_er  = ser[i];
      repeat (hold_n) @(posedge clk);
      #1;
    end
    sd.delete();
    sdv.delete();
    ser.delete();
  endtask

  // Builds a whole frame from the payload in pl and predicts its output from the framing rules.
  task automatic frame(input int npre, input bit bad, input int ncut, input bit tog, input bit inj);
    int   n;
    int   eb;
    int   ek;
    bit   good;
    exp_t e;
    n    = pl.size();
    good = !bad && (npre >= MIN_PRE);
    eb   = (n > 0) ? int'($urandom_range(n - 1, 0)) : 0;
    ek   = int'($urandom_range(3, 0));
    for (int i = 0; i < npre; i++) add(1, 2'b01, 0);
    if (bad) add(1, 2'b10, 0);
    add(1, 2'b11, 0);
    for (int b = 0; b < n; b++)
      for (int k = 0; k < 4; k++)
        add(!(tog && b >= n - 2 && (k == 0 || k == 2)), pl[b][2*k +: 2], inj && b == eb && k == ek);
    for (int i = 0; i < ncut; i++) add(1, 2'($urandom), 0);
    add(0, 2'($urandom), 0);
    add(0, 2'($urandom), 0);
    for (int i = 0; i < 3; i++) add(0, 2'b00, 0);
    if (good) begin
      for (int b = 0; b < n; b++) begin
        e.is_eof = 0; e.data = pl[b]; e.sof = (b == 0); e.err = 0; e.len = 0;
        exp_q.push_back(e);
      end
      e.is_eof = 1; e.data = 0; e.sof = 0; e.len = n;
      e.err = (inj && n > 0) || (ncut > 0) || (n == 0) || (n > MAX_LEN);
      exp_q.push_back(e);
    end
    play();
  endtask

  task automatic set_pl(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  initial begin
    exp_t e;
    int   n;
    bus.speed10 = 1'b0;
    bus.crs_dv  = 1'b0;
    bus.rx_d    = '0;
    bus.rx_er   = 1'b0;
    resetn      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs_zero("reset");
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    pl = {8'h01, 8'h02, 8'h03};
    frame(31, 0, 0, 0, 0);
    pl = {8'hC3, 8'h5A, 8'hE7, 8'h81};
    frame(31, 0, 0, 1, 0);

    // 10 Mb/s: each dibit held for DIV10 clocks
    bus.speed10 = 1'b1;
    hold_n      = DIV10;
    chk_spacing = 1;
    pl = {8'h01, 8'h02, 8'h03};
    frame(31, 0, 0, 0, 0);
    pl = {8'h3C, 8'h96, 8'h0F, 8'hF0};
    frame(12, 0, 0, 1, 0);
    chk_spacing = 0;
    bus.speed10 = 1'b0;
    hold_n      = 1;

    pl = {8'h11, 8'h22, 8'h33};
    frame(31, 0, 1, 0, 0);
    pl = {8'h44, 8'h55};
    frame(20, 0, 2, 1, 0);
    pl = {8'h77, 8'h88};
    frame(8, 1, 0, 0, 0);
    frame(2, 0, 0, 0, 0);
    frame(MIN_PRE, 0, 0, 0, 0);
    pl = {8'h99, 8'hAA, 8'hBB, 8'hCC};
    frame(31, 0, 0, 0, 1);

    pl.delete();
    frame(31, 0, 0, 0, 0);
    set_pl(MAX_LEN);
    frame(31, 0, 0, 0, 0);
    set_pl(MAX_LEN + 1);
    frame(31, 0, 0, 1, 0);

    // Reset in the middle of a frame: completed bytes come out, no end of frame follows
    pl = {8'hA1, 8'hB2};
    for (int i = 0; i < 8; i++) add(1, 2'b01, 0);
    add(1, 2'b11, 0);
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 4; k++) add(1, pl[b][2*k +: 2], 0);
    add(1, 2'b10, 0);
    for (int b = 0; b < 2; b++) begin
      e.is_eof = 0; e.data = pl[b]; e.sof = (b == 0); e.err = 0; e.len = 0;
      exp_q.push_back(e);
    end
    play();
    resetn     = 1'b0;
    bus.crs_dv = 1'b0;
    @(posedge clk);
    #1;
    chk_outs_zero("midrst");
    resetn = 1'b1;
    pl = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h42};
    frame(31, 0, 0, 0, 0);

    for (int f = 0; f < 25; f++) begin
      n = int'($urandom_range(30, 0));
      set_pl(n);
      frame(int'($urandom_range(31, MIN_PRE)), 0, int'($urandom_range(2, 0)),
            bit'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0));
      if (f % 6 == 5) begin
        set_pl(3);
        frame(int'($urandom_range(MIN_PRE - 1, 1)), 0, 0, 0, 0);
        frame(int'($urandom_range(20, 2)), 1, 0, 0, 0);
      end
    end

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
